// File: rtl/con1_pipe_bank.sv
// Multi-lane pipelined con1 evaluator with valid/ready flow control and
// per-lane saturating hit counters on the two outputs.

module con1_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       pi,
   output logic [1:0]       po,
   input  logic [1:0]       hit,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   assign po[0] = (pi[1] & (pi[4] | (~pi[0] & pi[5])))
                | (pi[3] & ((pi[0] & pi[2]) | (~pi[1] & ~pi[2])));
   assign po[1] = (pi[0] & ~(pi[4] & (pi[1] | pi[3])))
                | (~pi[0] & (~pi[6] | (pi[1] & pi[4])))
                | (~pi[1] & ~pi[4]);

   // clear wins over a same-cycle increment; counters stick at all-ones
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else if (inc) begin
         if (hit[0] && (cnt0 != '1)) cnt0 <= cnt0 + ONE;
         if (hit[1] && (cnt1 != '1)) cnt1 <= cnt1 + ONE;
      end
   end
endmodule

module con1_pipe_bank #(
   parameter int CHANNELS = 4,
   parameter int STAGES   = 2,
   parameter int CNT_W    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7*CHANNELS-1:0]     in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*CHANNELS-1:0]     out_data,
   input  logic                      cnt_clr,
   output logic [CNT_W*CHANNELS-1:0] cnt_po0,
   output logic [CNT_W*CHANNELS-1:0] cnt_po1
);
   logic                                 adv;
   logic                                 hs;
   logic [2*CHANNELS-1:0]                fn;
   logic [STAGES:1]                      vld_pipe;
   logic [STAGES:1][2*CHANNELS-1:0]      dat_pipe;

   assign adv       = ~out_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[STAGES];
   assign out_data  = dat_pipe[STAGES];
   assign hs        = out_valid & out_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      con1_lane #(.CNT_W(CNT_W)) u_lane (
         .clk  (clk),
         .rst  (rst),
         .pi   (in_data[7*c +: 7]),
         .po   (fn[2*c +: 2]),
         .hit  (out_data[2*c +: 2]),
         .inc  (hs),
         .clr  (cnt_clr),
         .cnt0 (cnt_po0[CNT_W*c +: CNT_W]),
         .cnt1 (cnt_po1[CNT_W*c +: CNT_W])
      );
   end

   // single global stall: every stage moves together or holds together;
   // bubbles carry zero data so invalid slots never expose stale results
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         dat_pipe <= '0;
      end else if (adv) begin
         vld_pipe[1] <= in_valid;
         dat_pipe[1] <= in_valid ? fn : '0;
         for (int s = 2; s <= STAGES; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end
endmodule
